adsr_envelope: RTL
==================

# adsr_envelope

Per-note ADSR (attack/decay/sustain/release) envelope generator and amplitude scaler in the synth signal chain. It consumes the note-control pulses decoded by the CPU memory-mapped I/O block: start, release, and reset (driven by the global synth reset or the per-note reset). It also consumes the NCO's summed sample stream and returns an envelope-scaled sample for the global-gain/PWM DAC path. It produces the `note_finished` status read back over MMIO.

## Interface
- `ENV_WIDTH`, 16: envelope level width (unsigned); `ENV_MAX = 2^ENV_WIDTH-1`.
- `SAMPLE_WIDTH`, 14: signed sample width in and out.
- `clk` in 1: single clock (signal-chain sample clock domain).
- `rst` in 1: synchronous, active-high reset.
- `note_start` in 1: one-cycle pulse; trigger or retrigger the attack.
- `note_release` in 1: one-cycle pulse; enter release.
- `note_reset` in 1: one-cycle pulse; abort the note immediately.
- `attack_step` in ENV_WIDTH: level increment per tick in ATTACK.
- `decay_step` in ENV_WIDTH: level decrement per tick in DECAY.
- `sustain_level` in ENV_WIDTH: DECAY floor and SUSTAIN hold level.
- `release_step` in ENV_WIDTH: level decrement per tick in RELEASE.
- `sample_valid` in 1: sample-rate tick strobe accompanying `sample_in`.
- `sample_in` in SAMPLE_WIDTH: signed NCO sample.
- `sample_out` out SAMPLE_WIDTH: signed scaled sample.
- `sample_out_valid` out 1: strobe, one cycle after `sample_valid`.
- `env_level` out ENV_WIDTH: current envelope level (registered).
- `env_state` out 3: current state encoding (debug/MMIO).
- `note_finished` out 1: sticky; release has completed.

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Event priority within one cycle: `note_reset` > `note_start` > `note_release`. Lower-priority events in the same cycle are dropped.
- `note_reset` (any state): level←0, state←IDLE, `note_finished`←0.
- `note_start` (any state): state←ATTACK, `note_finished`←0. The level is kept, not zeroed, so a retrigger from RELEASE/SUSTAIN ramps up from the current level without a click.
- `note_release`: from ATTACK/DECAY/SUSTAIN, state←RELEASE. Ignored in IDLE and RELEASE.
- Level steps occur only on cycles with `sample_valid=1` and no event pulse. An event cycle changes state only; no step is taken.
- ATTACK: if level+attack_step ≥ ENV_MAX (computed at ENV_WIDTH+1 bits), level←ENV_MAX and state←DECAY. Otherwise level+=attack_step.
- DECAY: if level ≤ sustain_level+decay_step (computed at ENV_WIDTH+1 bits), level←sustain_level and state←SUSTAIN. Otherwise level−=decay_step.
- SUSTAIN: level←sustain_level each tick, so live config changes track.
- RELEASE: if level ≤ release_step, level←0, state←IDLE, `note_finished`←1. Otherwise level−=release_step.
- A step value of 0 holds the level in that state indefinitely. This is legal; software must avoid it.
- Config inputs are sampled live on every tick and are not latched at `note_start`.
- Scaling: `sample_out = (sample_in × {1'b0, level}) >>> ENV_WIDTH`. Signed multiply, arithmetic shift, result truncated to SAMPLE_WIDTH. It cannot overflow because level ≤ ENV_MAX < 2^ENV_WIDTH.
- `sample_out` uses the level registered before that tick's update.

## Timing
- Reset values: state IDLE, `env_level` 0, `sample_out` 0, `sample_out_valid` 0, `note_finished` 0, `env_state` IDLE.
- An event pulse at cycle N gives the new `env_state` at N+1.
- A tick at N gives the updated `env_level` and state at N+1. `note_finished` rises at N+1 of the final release tick.
- `sample_valid` at N gives `sample_out`/`sample_out_valid` at N+1. Latency is 1 and throughput is one sample per cycle. `sample_out` holds its value between strobes.
- `rst` overrides everything, including mid-release and a same-cycle `note_start`.
- `note_finished` stays high until `note_start`, `note_reset`, or `rst`.

## Structure
- Package `adsr_pkg`: state enum (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4) and the `ENV_MAX` constant function.
- Sub-module `env_scale`: registered signed×unsigned multiply with arithmetic shift, and valid-strobe delay.
- FSM and saturating level arithmetic live in the top module.

## Test plan
- Attack/decay: attack_step=0x4000, decay_step=0x1000, sustain=0xC000, start then ticks → levels 0x4000, 0x8000, 0xC000, 0xFFFF (→DECAY), then 0xEFFF, 0xDFFF, 0xCFFF, 0xC000 (→SUSTAIN).
- Release: from SUSTAIN 0xC000, release_step=0x4000, release then ticks → 0x8000, 0x4000, 0x0000, state IDLE; `note_finished`=1 the cycle after the third tick, then cleared by `note_start`.
- Scaling: level 0x8000 with sample_in 8191 → 4095; with −8192 → −4096. Level 0 → 0. `sample_out_valid` exactly one cycle after each `sample_valid`.
- Priority and same-cycle: `note_start`+`note_release` together → ATTACK. `note_reset`+`note_start` → IDLE with level 0. An event on a tick cycle → no level change that cycle.
- Retrigger: `note_start` in RELEASE at level 0x3000 → ATTACK continues from 0x3000. `note_release` in IDLE → no effect.
- Reset mid-operation: `rst` during ATTACK at 0x8000 → all outputs reach reset values next cycle.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope generator.
package adsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    function automatic int unsigned env_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/env_scale.sv
// Registered amplitude scaler: signed sample times unsigned envelope level,
// renormalised by the level width, with a one-cycle delayed valid strobe.
module env_scale
    import adsr_pkg::*;
#(
    parameter int ENV_WIDTH    = 16,
    parameter int SAMPLE_WIDTH = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_valid,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic        [ENV_WIDTH-1:0]    level,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_out_valid
);

    localparam int PW = SAMPLE_WIDTH + ENV_WIDTH + 1;

    logic signed [PW-1:0]           product_s;
    logic signed [SAMPLE_WIDTH-1:0] scaled_d;
    logic signed [SAMPLE_WIDTH-1:0] sample_out_q;
    logic                           out_valid_q;
    logic                           unused_bits_s;

    // Level is zero-extended so the multiply stays signed x non-negative;
    // taking bits above ENV_WIDTH is the arithmetic shift plus truncation.
    always_comb begin
        product_s = PW'(sample_in) * PW'(signed'({1'b0, level}));
        scaled_d  = product_s[ENV_WIDTH +: SAMPLE_WIDTH];
    end

    assign unused_bits_s = ^{product_s[ENV_WIDTH-1:0], product_s[PW-1]};

    // Output register: sample holds between strobes, valid follows one cycle late.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            out_valid_q <= sample_valid;
            if (sample_valid) begin
                sample_out_q <= scaled_d;
            end
        end
    end

    assign sample_out       = sample_out_q;
    assign sample_out_valid = out_valid_q;

endmodule

// File: rtl/adsr_envelope.sv
// Per-note ADSR envelope FSM with saturating level arithmetic, driving a
// registered sample scaler.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int ENV_WIDTH    = 16,
    parameter int SAMPLE_WIDTH = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           note_start,
    input  logic                           note_release,
    input  logic                           note_reset,
    input  logic        [ENV_WIDTH-1:0]    attack_step,
    input  logic        [ENV_WIDTH-1:0]    decay_step,
    input  logic        [ENV_WIDTH-1:0]    sustain_level,
    input  logic        [ENV_WIDTH-1:0]    release_step,
    input  logic                           sample_valid,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_out_valid,
    output logic        [ENV_WIDTH-1:0]    env_level,
    output logic        [2:0]              env_state,
    output logic                           note_finished
);

    localparam logic [ENV_WIDTH-1:0] ENV_MAX = ENV_WIDTH'(env_max(ENV_WIDTH));

    env_state_e           state_q, state_d;
    logic [ENV_WIDTH-1:0] level_q, level_d;
    logic                 finished_q, finished_d;
    logic [ENV_WIDTH:0]   attack_sum_s;
    logic [ENV_WIDTH:0]   decay_floor_s;

    // State, level and sticky finished flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            level_q    <= '0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            finished_q <= finished_d;
        end
    end

    // Events take priority and suppress the tick; comparisons use one extra
    // bit so the step sums cannot wrap.
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        finished_d    = finished_q;
        attack_sum_s  = {1'b0, level_q} + {1'b0, attack_step};
        decay_floor_s = {1'b0, sustain_level} + {1'b0, decay_step};

        if (note_reset) begin
            state_d    = ST_IDLE;
            level_d    = '0;
            finished_d = 1'b0;
        end else if (note_start) begin
            state_d    = ST_ATTACK;
            finished_d = 1'b0;
        end else if (note_release) begin
            if ((state_q == ST_ATTACK) || (state_q == ST_DECAY) || (state_q == ST_SUSTAIN)) begin
                state_d = ST_RELEASE;
            end else begin
                state_d = state_q;
            end
        end else if (sample_valid) begin
            case (state_q)
                ST_IDLE: begin
                    level_d = level_q;
                end
                ST_ATTACK: begin
                    if (attack_sum_s >= {1'b0, ENV_MAX}) begin
                        level_d = ENV_MAX;
                        state_d = ST_DECAY;
                    end else begin
                        level_d = attack_sum_s[ENV_WIDTH-1:0];
                    end
                end
                ST_DECAY: begin
                    if ({1'b0, level_q} <= decay_floor_s) begin
                        level_d = sustain_level;
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = level_q - decay_step;
                    end
                end
                ST_SUSTAIN: begin
                    level_d = sustain_level;
                end
                ST_RELEASE: begin
                    if (level_q <= release_step) begin
                        level_d    = '0;
                        state_d    = ST_IDLE;
                        finished_d = 1'b1;
                    end else begin
                        level_d = level_q - release_step;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Scaler sees the level as it was before this tick's update.
    env_scale #(
        .ENV_WIDTH    (ENV_WIDTH),
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_env_scale (
        .clk              (clk),
        .rst              (rst),
        .sample_valid     (sample_valid),
        .sample_in        (sample_in),
        .level            (level_q),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid)
    );

    assign env_level     = level_q;
    assign env_state     = state_q;
    assign note_finished = finished_q;

endmodule
